wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter and register scoreboard for the integer regfile. It merges two writeback requesters, the ALU result path (port A) and the load path (port B), onto the regfile's single write port (`wr_enable`/`wr_addr`/`wr_data`). Each requester has a 2-entry FIFO and the block grants them round-robin. It also keeps a 32-bit busy scoreboard: the decode stage reserves destination registers at issue, and committed writes release them.

## Interface
Parameters:
- `ADDR_W`, 5: register address width; 2^ADDR_W registers.
- `DATA_W`, 32: register data width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `a_valid`  in  1  port A writeback request.
- `a_ready`  out  1  port A FIFO can accept (count < 2).
- `a_addr`  in  ADDR_W  port A destination register.
- `a_data`  in  DATA_W  port A result.
- `b_valid`, `b_ready`, `b_addr`, `b_data`: same as port A, for port B.
- `rsv_valid`  in  1  reserve destination at issue.
- `rsv_addr`  in  ADDR_W  register to mark busy.
- `wr_enable`  out  1  regfile write strobe, registered.
- `wr_addr`  out  ADDR_W  regfile write address, registered.
- `wr_data`  out  DATA_W  regfile write data, registered.
- `busy`  out  2^ADDR_W  scoreboard; bit n = register n has a write in flight; bit 0 is constant 0.
- `idle`  out  1  both FIFOs empty, `wr_enable` low, and `busy` == 0.

## Operation
- **Handshake:** a transfer occurs on a rising edge where `x_valid && x_ready`. Data is pushed into FIFO x (2 entries, addr+data).
  - `x_ready = (count_x < 2)`; it depends only on registered state, with no combinational path from `x_valid`.
  - `x_valid` is ignored while `x_ready` is low. Nothing is lost; the requester holds.
- **Arbitration:** runs every cycle over the FIFO heads.
  - Only one head present: grant it.
  - Both present: grant the side selected by `rr` (0 = A, 1 = B). `rr` toggles to the non-granted side after every contested grant.
  - Uncontested grants leave `rr` unchanged.
- **Granted entry:** popped in the same edge, and its addr/data loaded into `wr_addr`/`wr_data`. `wr_enable` is set to 1 if addr != 0, otherwise 0. An addr-0 entry still consumes the grant slot.
- **No grant:** `wr_enable` is 0. `wr_addr` and `wr_data` hold their last values.
- **Simultaneous push and pop on one FIFO:** both take effect and the count is unchanged. A FIFO at count 2 can pop but not push that cycle, because ready was low.
- **Scoreboard:**
  - At each edge, if `wr_enable` is high, `busy[wr_addr]` clears. This is the same edge at which the regfile commits.
  - If `rsv_valid && rsv_addr != 0`, `busy[rsv_addr]` sets.
  - Same address set and cleared in the same edge: set wins, because a newer producer is in flight.
  - Reserve of address 0 is ignored.
  - Reserving an already-busy register keeps it busy. There is no count per register; issue logic must stall on `busy` before re-reserving.
- **Ordering:** entries from the same port are written in push order. No ordering is guaranteed between A and B.

## Timing
- **Reset (asynchronous assert):**
  - FIFOs empty; `a_ready` = `b_ready` = 1.
  - `rr` = 0; `wr_enable` = 0; `wr_addr` = 0; `wr_data` = 0.
  - `busy` = 0; `idle` = 1.
  - Reset mid-operation discards all pending entries and reservations.
- **Write latency:**
  - Push at edge N to an empty FIFO with no contention: `wr_enable` is high during cycle N+1 to N+2.
  - The regfile commits at edge N+2; the `busy` bit clears at that edge.
- **Throughput:** one write per cycle total. A single uncontested port sustains 1 push per cycle with `ready` held high.
- **Contention:** with both ports streaming, grants alternate A,B,A,B. Each port's FIFO fills and its `ready` toggles to give an effective 1/2 rate.
- **Worst-case wait:** a head entry waits at most 1 cycle for a grant.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle, with both FIFOs holding 2 entries and `busy`=0x0000_00F0 -> outputs are 0 immediately, `ready`=1, `idle`=1; no write after release.
- **Single write:** A pushes addr 5, data 0xDEADBEEF at edge N, after `rsv` of 5 at N-2 -> `wr_enable`=1 and `wr_addr`=5 in cycle N+1; `busy[5]` clears at N+2; `idle`=1 at N+2.
- **Contention:**
  - Both ports push 4 entries each (A: addr 1–4, B: addr 11–14) from the same edge.
  - Required: `wr_addr` sequence 1,11,2,12,3,13,4,14 with no gaps; `ready` is never violated.
  - Per-port order is preserved.
- **Address 0:** B pushes addr 0, data 0x1234 -> grant consumed, `wr_enable` stays 0, and the FIFO drains.
- **Reserve vs. commit collision:** `rsv` addr 7 in the same cycle `wr_enable` writes addr 7 -> `busy[7]`=1 afterwards. `rsv` addr 0 -> `busy`=0.
- **Backpressure:** hold A valid for 3 entries while B is contended.
  - Required: `a_ready` drops after 2 entries are pending; the 3rd is accepted only once `a_ready` returns.
  - No entry is lost or duplicated; a scoreboard model matches `busy` every cycle.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin merge of two 2-entry writeback FIFOs onto the regfile
// write port, plus a per-register busy scoreboard.
module wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_data,
  input  logic                 rsv_valid,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic                 wr_enable,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 idle
);
  localparam int N = 2**ADDR_W;
  logic [1:0] in_valid, ready, has, pop;
  logic [ADDR_W-1:0] in_addr [2];
  logic [DATA_W-1:0] in_data [2];
  logic [ADDR_W-1:0] head_addr [2];
  logic [DATA_W-1:0] head_data [2];
  logic rr, gnt_b;
  logic [N-1:0] clr, set;
  assign in_valid = {b_valid, a_valid};
  assign in_addr = '{a_addr, b_addr};
  assign in_data = '{a_data, b_data};
  assign a_ready = ready[0];
  assign b_ready = ready[1];
  for (genvar p = 0; p < 2; p++) begin : g_fifo
    logic [1:0] cnt;
    logic [ADDR_W-1:0] qa [2];
    logic [DATA_W-1:0] qd [2];
    logic push, slot;
    assign ready[p] = ~cnt[1];
    assign has[p] = |cnt;
    assign push = in_valid[p] & ready[p];
    // head lives in slot 0; a push lands behind whatever survives this edge's pop
    assign slot = cnt[0] & ~pop[p];
    assign head_addr[p] = qa[0];
    assign head_data[p] = qd[0];
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        cnt <= '0;
        qa <= '{default: '0};
        qd <= '{default: '0};
      end else begin
        if (pop[p]) begin
          qa[0] <= qa[1];
          qd[0] <= qd[1];
        end
        if (push) begin
          qa[slot] <= in_addr[p];
          qd[slot] <= in_data[p];
        end
        cnt <= cnt + {1'b0, push} - {1'b0, pop[p]};
      end
  end
  assign gnt_b = has[1] & (~has[0] | rr);
  assign pop = {gnt_b, has[0] & ~gnt_b};
  always_comb begin
    clr = '0;
    set = '0;
    clr[wr_addr] = wr_enable;
    set[rsv_addr] = rsv_valid & |rsv_addr;
  end
  // set is applied after clear so a fresh reservation beats a same-edge commit
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rr <= 1'b0;
      wr_enable <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy <= '0;
    end else begin
      if (&has) rr <= ~rr;
      wr_enable <= |pop & |head_addr[gnt_b];
      if (|pop) begin
        wr_addr <= head_addr[gnt_b];
        wr_data <= head_data[gnt_b];
      end
      busy <= (busy & ~clr) | set;
    end
  assign idle = ~|has & ~wr_enable & ~|busy;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus with an expected-write queue checked by an
// independent monitor, plus a busy-scoreboard model compared every cycle.
`timescale 1ns/1ps
module tb_wb_arbiter;
  logic clk = 0, reset = 1;
  logic a_valid = 0, b_valid = 0, rsv_valid = 0;
  logic [4:0] a_addr = 0, b_addr = 0, rsv_addr = 0;
  logic [31:0] a_data = 0, b_data = 0;
  logic a_ready, b_ready, wr_enable, idle;
  logic [4:0] wr_addr;
  logic [31:0] wr_data, busy;
  typedef struct {
    logic [4:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t q[$];
  int checks = 0, errors = 0;
  logic [31:0] model = 0;
  logic clr_pend = 0;
  logic [4:0] clr_addr = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .idle(idle)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dval(input bit p, input logic [4:0] ad);
    return {p ? 8'hB0 : 8'hA0, 19'd0, ad};
  endfunction

  task automatic exp_wr(input logic [4:0] ad, input logic [31:0] d);
    wr_t e;
    e.addr = ad;
    e.data = d;
    q.push_back(e);
  endtask

  // busy model: reservations come from the stimulus, releases from the expected write list
  always @(posedge clk or posedge reset)
    if (reset) model <= '0;
    else model <= (model & ~(clr_pend ? 32'd1 << clr_addr : 32'd0))
                  | ((rsv_valid && rsv_addr != 0) ? 32'd1 << rsv_addr : 32'd0);

  always @(negedge clk) begin
    wr_t e;
    clr_pend = 0;
    if (reset) q.delete();
    else begin
      check("busy_model", busy, model);
      if (wr_enable) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %h, expected no write", wr_addr, wr_data);
        end else begin
          e = q.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data) begin
            errors++;
            $display("FAIL wr_seq: got addr %0d data %h expected addr %0d data %h", wr_addr, wr_data, e.addr, e.data);
          end
          clr_pend = 1;
          clr_addr = e.addr;
        end
      end
    end
  end

  task automatic drive(input bit p, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      bit acc = 0;
      int t = 0;
      logic [4:0] ad = 5'(base + i);
      if (p) begin b_valid = 1; b_addr = ad; b_data = dval(1, ad); end
      else begin a_valid = 1; a_addr = ad; a_data = dval(0, ad); end
      while (!acc && t < 20) begin
        acc = p ? b_ready : a_ready;
        @(negedge clk);
        t++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL push_timeout: port %0d addr %0d not accepted, expected acceptance", p, ad);
      end
    end
    if (p) b_valid = 0; else a_valid = 0;
  endtask

  task automatic run_len(input int want);
    int t = 0, n = 0;
    while (!wr_enable && t < 20) begin @(negedge clk); t++; end
    while (wr_enable && n < 20) begin n++; @(negedge clk); end
    check("burst_len", n, want);
  endtask

  task automatic low_count(input int cycles, input int want);
    int n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (!a_ready) n++;
      @(negedge clk);
    end
    check("a_ready_low_cycles", n, want);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 50) begin @(negedge clk); t++; end
    check("drain", q.size(), 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    reset = 0;
    check("rst_wr_enable", wr_enable, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_idle", idle, 1);
    check("rst_ready", {a_ready, b_ready}, 2'b11);
    // single write: reserve at N-2, push at N
    rsv_valid = 1; rsv_addr = 5;
    @(negedge clk); rsv_valid = 0;
    @(negedge clk); a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF; exp_wr(5, 32'hDEADBEEF);
    @(negedge clk); a_valid = 0;
    check("single_busy_set", busy, 32'h20);
    check("single_not_idle", idle, 0);
    @(negedge clk);
    check("single_wr_enable", wr_enable, 1);
    check("single_wr_addr", wr_addr, 5);
    @(negedge clk);
    check("single_busy_clear", busy, 0);
    check("single_idle", idle, 1);
    // reserve of 7 lands on the edge that commits 7
    rsv_valid = 1; rsv_addr = 7;
    @(negedge clk); rsv_valid = 0; a_valid = 1; a_addr = 7; a_data = 32'h77; exp_wr(7, 32'h77);
    @(negedge clk); a_valid = 0;
    @(negedge clk); rsv_valid = 1; rsv_addr = 7;
    check("collide_wr_enable", wr_enable, 1);
    @(negedge clk); rsv_valid = 0;
    check("collide_set_wins", busy, 32'h80);
    a_valid = 1; a_addr = 7; a_data = 32'h78; exp_wr(7, 32'h78);
    @(negedge clk); a_valid = 0;
    repeat (2) @(negedge clk);
    check("collide_release", busy, 0);
    rsv_valid = 1; rsv_addr = 0;
    @(negedge clk); rsv_valid = 0;
    check("rsv_zero_ignored", busy, 0);
    // address 0 consumes a grant but never writes
    b_valid = 1; b_addr = 0; b_data = 32'h1234;
    @(negedge clk); b_valid = 0;
    @(negedge clk);
    check("addr0_no_write", wr_enable, 0);
    check("addr0_wr_data", wr_data, 32'h1234);
    check("addr0_wr_addr", wr_addr, 0);
    check("addr0_drained", idle, 1);
    // contention: strict alternation from rr = 0
    for (int i = 0; i < 4; i++) begin
      exp_wr(5'(1 + i), dval(0, 5'(1 + i)));
      exp_wr(5'(11 + i), dval(1, 5'(11 + i)));
    end
    fork
      drive(0, 1, 4);
      drive(1, 11, 4);
      run_len(8);
    join
    drain();
    // backpressure: rr now points at B, A holds its third entry
    for (int i = 0; i < 6; i++) begin
      rsv_valid = 1; rsv_addr = 5'(21 + i);
      @(negedge clk);
    end
    rsv_valid = 0;
    check("bp_busy_reserved", busy, 32'h07E0_0000);
    exp_wr(24, dval(1, 24)); exp_wr(21, dval(0, 21));
    exp_wr(25, dval(1, 25)); exp_wr(22, dval(0, 22));
    exp_wr(26, dval(1, 26)); exp_wr(23, dval(0, 23));
    fork
      drive(0, 21, 3);
      drive(1, 24, 3);
      low_count(8, 2);
    join
    drain();
    repeat (2) @(negedge clk);
    check("bp_busy_clear", busy, 0);
    check("bp_idle", idle, 1);
    // asynchronous reset with entries pending and busy = 0xF0
    for (int i = 4; i < 8; i++) begin
      rsv_valid = 1; rsv_addr = 5'(i);
      @(negedge clk);
    end
    rsv_valid = 0;
    a_valid = 1; a_addr = 8; a_data = dval(0, 8);
    b_valid = 1; b_addr = 9; b_data = dval(1, 9);
    exp_wr(8, dval(0, 8));
    @(negedge clk);
    a_addr = 10; a_data = dval(0, 10);
    b_addr = 11; b_data = dval(1, 11);
    @(negedge clk); a_valid = 0; b_valid = 0;
    check("pre_rst_busy", busy, 32'hF0);
    check("pre_rst_b_full", b_ready, 0);
    #2 reset = 1;
    #1;
    check("async_rst_wr_enable", wr_enable, 0);
    check("async_rst_wr_addr", wr_addr, 0);
    check("async_rst_wr_data", wr_data, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", {a_ready, b_ready}, 2'b11);
    check("async_rst_idle", idle, 1);
    @(posedge clk);
    @(negedge clk); reset = 0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (wr_enable) n++;
    end
    check("post_rst_no_write", n, 0);
    check("post_rst_idle", idle, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
